ysyx_23060077_predecode_queue: RTL and testbench
================================================

// Module: ysyx_23060077_predecode_queue
// PURPOSE
//  Parametrised instruction queue between IFU and IDU. Pre-decodes each fetched
//  instruction on enqueue (jal/jalr/branch/sys/ecall/mret), applies static
//  prediction (jal and backward branch taken), issues a one-cycle redirect to
//  fetch, and serialises fetch behind SYSTEM instructions. Replaces the purely
//  combinational pre-decode at the IFU output.
// PARAMETERS
//  XLEN        32  PC / address width
//  DEPTH       4   queue entries; power of two, >= 2
//  PRED_EN     1   1: static prediction + redirect enabled; 0: pred_taken and redirect held 0
//  PRE_W       6   pre-decode vector width; bit order JAL,JALR,BRANCH,SYS,ECALL,MRET = [0..5]
// PORTS
//  clk             in   1      clock, all state on rising edge
//  rst_n           in   1      asynchronous active-low reset
//  flush_i         in   1      pipeline flush (EXU redirect / trap), synchronous
//  in_valid        in   1      IFU has an instruction
//  in_ready        out  1      queue accepts it
//  in_pc           in   XLEN   PC of instruction
//  in_inst         in   32     instruction word
//  out_valid       out  1      head entry valid
//  out_ready       in   1      IDU consumes head
//  out_pc          out  XLEN   head PC
//  out_inst        out  32     head instruction
//  out_predecode   out  PRE_W  head pre-decode vector
//  out_pred_taken  out  1      head predicted taken
//  out_pred_target out  XLEN   head predicted target (0 when not taken)
//  redirect_valid  out  1      one-cycle pulse: fetch must restart at redirect_pc
//  redirect_pc     out  XLEN   predicted target
//  count           out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  Reset: all outputs 0, count 0, pointers 0, entry storage 0, sys_lock 0.
//  Pre-decode (on in_inst, opcode=inst[6:0]): JAL 1101111; JALR 1100111;
//   BRANCH 1100011; SYS 1110011; ECALL SYS & f3==000 & inst[31:20]==0;
//   MRET SYS & f3==000 & inst[31:20]==12'h302.
//  Prediction (PRED_EN=1): taken = JAL | (BRANCH & inst[31]). JALR never predicted.
//   J-imm {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}, B-imm
//   {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}, sign-extended to XLEN;
//   target = in_pc + imm modulo 2^XLEN (wrap, no overflow flag).
//  Enqueue: fire_in = in_valid & in_ready; entry {pc,inst,predecode,taken,target}
//   written at wr_ptr, wr_ptr++ (wraps mod DEPTH).
//  in_ready = !flush_i & (count<DEPTH) & !redirect_valid & !sys_lock.
//   Full queue: no enqueue even if head dequeues same cycle (no pass-through).
//  Dequeue: out_valid = (count!=0); fire_out = out_valid & out_ready; rd_ptr++.
//   out_* show entry at rd_ptr; latency enqueue->out_valid = 1 cycle, no bypass.
//  Simultaneous fire_in & fire_out: count unchanged, both pointers advance.
//  Redirect: fire_in of a predicted-taken entry -> next cycle redirect_valid=1,
//   redirect_pc=target, for exactly one cycle; in_ready=0 that cycle (wrong-path
//   word on in_* is not accepted; IFU discards it).
//  SYS lock: fire_in of SYS entry sets sys_lock next cycle; cleared on the cycle
//   that entry is dequeued (fire_out with head SYS). in_ready=0 while locked.
//  Flush (highest priority): next cycle count=0, pointers=0, redirect_valid=0,
//   sys_lock=0; same-cycle in/out handshakes are ignored (in_ready=0, no dequeue
//   state change). out_valid=0 the cycle after flush.
//  Reset asserted mid-operation: immediate return to reset values, queue contents lost.
// TESTING
//  1 Reset: rst_n=0 -> in_ready=0? no: in_ready=1, out_valid=0, count=0, redirect_valid=0.
//  2 Fill: 4 non-control insts, out_ready=0 -> count=4, in_ready=0; drain in order, PCs match.
//  3 JAL pc=0x8000_0000 inst=0x0080_006F -> out_predecode=000001, target 0x8000_0008,
//    redirect_valid 1 cycle, in_ready=0 that cycle.
//  4 BEQ backward inst=0xFE00_0EE3 pc=0x100 -> taken, target 0xFC; forward BEQ
//    0x0000_0463 -> taken=0, no redirect.
//  5 ECALL 0x0000_0073 -> predecode 011000, sys_lock blocks in_ready until dequeued;
//    MRET 0x3020_0073 -> 101000 (bits MRET,SYS).
//  6 Flush with count=3 while in_valid=1 -> next cycle count=0, out_valid=0, nothing enqueued;
//    JAL at pc=0xFFFF_FFFC imm=+8 -> target 0x0000_0004 (wrap).

Source files
------------

// File: rtl/ysyx_23060077_predecode_queue.sv
// Instruction queue between IFU and IDU: pre-decodes control-flow and SYSTEM
// instructions on enqueue, predicts jal/backward branches taken and redirects fetch.
module ysyx_23060077_predecode_queue #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter bit PRED_EN = 1'b1,
  parameter int PRE_W   = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [31:0]                  in_inst,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [31:0]                  out_inst,
  output logic [PRE_W-1:0]             out_predecode,
  output logic                         out_pred_taken,
  output logic [XLEN-1:0]              out_pred_target,
  output logic                         redirect_valid,
  output logic [XLEN-1:0]              redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  localparam int PD_JAL    = 0;
  localparam int PD_JALR   = 1;
  localparam int PD_BRANCH = 2;
  localparam int PD_SYS    = 3;
  localparam int PD_ECALL  = 4;
  localparam int PD_MRET   = 5;

  function automatic logic [PRE_W-1:0] predecode(
    input logic [6:0]  opcode,
    input logic [2:0]  funct3,
    input logic [11:0] imm12
  );
    logic [PRE_W-1:0] pd;
    logic             sys_base;
    pd = {PRE_W{1'b0}};
    sys_base          = (opcode == 7'b1110011) && (funct3 == 3'b000);
    pd[PD_JAL]        = (opcode == 7'b1101111);
    pd[PD_JALR]       = (opcode == 7'b1100111);
    pd[PD_BRANCH]     = (opcode == 7'b1100011);
    pd[PD_SYS]        = (opcode == 7'b1110011);
    pd[PD_ECALL]      = sys_base && (imm12 == 12'h000);
    pd[PD_MRET]       = sys_base && (imm12 == 12'h302);
    return pd;
  endfunction

  function automatic logic [XLEN-1:0] j_imm(input logic [31:12] hi);
    return {{(XLEN-21){hi[31]}}, hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] b_imm(input logic [31:25] hi, input logic [11:7] lo);
    return {{(XLEN-13){hi[31]}}, hi[31], lo[7], hi[30:25], lo[11:8], 1'b0};
  endfunction

  logic [XLEN-1:0]  pc_q     [DEPTH];
  logic [31:0]      inst_q   [DEPTH];
  logic [PRE_W-1:0] pre_q    [DEPTH];
  logic             taken_q  [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic             sys_lock_q, sys_lock_d;

  logic [PRE_W-1:0] pre_s;
  logic             taken_s;
  logic [XLEN-1:0]  imm_s;
  logic [XLEN-1:0]  target_s;
  logic             in_ready_s;
  logic             fire_in_s;
  logic             fire_out_s;
  logic             head_sys_s;

  // Pre-decode and static prediction of the incoming word
  always_comb begin
    pre_s = predecode(in_inst[6:0], in_inst[14:12], in_inst[31:20]);
    if (PRED_EN) begin
      taken_s = pre_s[PD_JAL] | (pre_s[PD_BRANCH] & in_inst[31]);
    end else begin
      taken_s = 1'b0;
    end
    if (pre_s[PD_JAL]) begin
      imm_s = j_imm(in_inst[31:12]);
    end else begin
      imm_s = b_imm(in_inst[31:25], in_inst[11:7]);
    end
    if (taken_s) begin
      target_s = in_pc + imm_s;
    end else begin
      target_s = {XLEN{1'b0}};
    end
  end

  // Handshakes; flush blocks both sides, a redirect cycle drops the wrong-path word
  always_comb begin
    in_ready_s = !flush_i && (count_q < CNT_FULL) && !redirect_valid_q && !sys_lock_q;
    fire_in_s  = in_valid && in_ready_s;
    fire_out_s = (count_q != {CW{1'b0}}) && out_ready && !flush_i;
    head_sys_s = pre_q[rd_ptr_q][PD_SYS];
  end

  // Next-state for pointers, occupancy, redirect pulse and SYSTEM lock
  always_comb begin
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = {XLEN{1'b0}};
    sys_lock_d       = sys_lock_q;
    if (flush_i) begin
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      count_d    = {CW{1'b0}};
      sys_lock_d = 1'b0;
    end else begin
      if (fire_in_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (fire_out_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({fire_in_s, fire_out_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (fire_in_s && pre_s[PD_SYS]) begin
        sys_lock_d = 1'b1;
      end else if (fire_out_s && head_sys_s) begin
        sys_lock_d = 1'b0;
      end else begin
        sys_lock_d = sys_lock_q;
      end
      if (fire_in_s && taken_s) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = target_s;
      end else begin
        redirect_valid_d = 1'b0;
        redirect_pc_d    = {XLEN{1'b0}};
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q         <= {PW{1'b0}};
      rd_ptr_q         <= {PW{1'b0}};
      count_q          <= {CW{1'b0}};
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= {XLEN{1'b0}};
      sys_lock_q       <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      sys_lock_q       <= sys_lock_d;
    end
  end

  // Entry storage, written at the tail on every accepted word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]     <= {XLEN{1'b0}};
        inst_q[i]   <= 32'h0000_0000;
        pre_q[i]    <= {PRE_W{1'b0}};
        taken_q[i]  <= 1'b0;
        target_q[i] <= {XLEN{1'b0}};
      end
    end else if (fire_in_s) begin
      pc_q[wr_ptr_q]     <= in_pc;
      inst_q[wr_ptr_q]   <= in_inst;
      pre_q[wr_ptr_q]    <= pre_s;
      taken_q[wr_ptr_q]  <= taken_s;
      target_q[wr_ptr_q] <= target_s;
    end
  end

  assign in_ready        = in_ready_s;
  assign out_valid       = (count_q != {CW{1'b0}});
  assign out_pc          = pc_q[rd_ptr_q];
  assign out_inst        = inst_q[rd_ptr_q];
  assign out_predecode   = pre_q[rd_ptr_q];
  assign out_pred_taken  = taken_q[rd_ptr_q];
  assign out_pred_target = target_q[rd_ptr_q];
  assign redirect_valid  = redirect_valid_q;
  assign redirect_pc     = redirect_pc_q;
  assign count           = count_q;

endmodule

// File: tb/tb_ysyx_23060077_predecode_queue.sv
// Self-checking bench: directed scenarios plus random traffic compared each cycle
// against a queue-based reference model of the pre-decode queue.
module tb_ysyx_23060077_predecode_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int PRE_W = 6;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [XLEN-1:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic in_ready, out_valid, out_pred_taken, redirect_valid;
  logic [XLEN-1:0] out_pc, out_pred_target, redirect_pc;
  logic [31:0] out_inst;
  logic [PRE_W-1:0] out_predecode;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  ysyx_23060077_predecode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .PRED_EN(1'b1), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_predecode(out_predecode), .out_pred_taken(out_pred_taken),
    .out_pred_target(out_pred_target), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .count(count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  pre;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  ent_t q[$];
  bit m_redir = 1'b0;
  logic [31:0] m_redir_pc = '0;
  bit m_lock = 1'b0;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference pre-decode straight from the opcode table
  function automatic logic [5:0] m_pre(input logic [31:0] w);
    logic [5:0] p;
    bit sys, base;
    sys  = (w[6:0] == 7'h73);
    base = sys && (w[14:12] == 3'd0);
    p    = 6'd0;
    p[0] = (w[6:0] == 7'h6F);
    p[1] = (w[6:0] == 7'h67);
    p[2] = (w[6:0] == 7'h63);
    p[3] = sys;
    p[4] = base && (w[31:20] == 12'h000);
    p[5] = base && (w[31:20] == 12'h302);
    return p;
  endfunction

  function automatic bit m_taken(input logic [31:0] w);
    return (w[6:0] == 7'h6F) || ((w[6:0] == 7'h63) && w[31]);
  endfunction

  // Target via signed integer arithmetic on the immediate fields
  function automatic logic [31:0] m_target(input logic [31:0] pc, input logic [31:0] w);
    longint imm, neg;
    if (w[6:0] == 7'h6F) begin
      neg = w[31] ? 64'd1048576 : 64'd0;
      imm = (longint'(w[19:12]) * 4096) + (longint'(w[20]) * 2048) + (longint'(w[30:21]) * 2) - neg;
    end else begin
      neg = w[31] ? 64'd4096 : 64'd0;
      imm = (longint'(w[7]) * 2048) + (longint'(w[30:25]) * 32) + (longint'(w[11:8]) * 2) - neg;
    end
    return 32'(longint'(pc) + imm);
  endfunction

  task automatic set(input bit v, input logic [31:0] pc, input logic [31:0] w, input bit ordy, input bit fl);
    in_valid = v; in_pc = pc; in_inst = w; out_ready = ordy; flush_i = fl;
  endtask

  // Compare all outputs to the model, then advance the model across the next edge
  task automatic tick();
    ent_t e;
    bit exp_ready, fin, fout;
    #1;
    exp_ready = !flush_i && (q.size() < DEPTH) && !m_redir && !m_lock;
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, q.size() != 0);
    chk("count", count, q.size());
    chk("redirect_valid", redirect_valid, m_redir);
    if (m_redir) chk("redirect_pc", redirect_pc, m_redir_pc);
    if (q.size() != 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_inst", out_inst, q[0].inst);
      chk("out_predecode", out_predecode, q[0].pre);
      chk("out_pred_taken", out_pred_taken, q[0].taken);
      chk("out_pred_target", out_pred_target, q[0].target);
    end
    fin  = in_valid && exp_ready;
    fout = (q.size() != 0) && out_ready && !flush_i;
    if (flush_i) begin
      q.delete(); m_redir = 1'b0; m_lock = 1'b0;
    end else begin
      if (fout) begin
        if (q[0].pre[3]) m_lock = 1'b0;
        void'(q.pop_front());
      end
      m_redir = 1'b0;
      if (fin) begin
        e.pc = in_pc; e.inst = in_inst; e.pre = m_pre(in_inst);
        e.taken = m_taken(in_inst);
        e.target = e.taken ? m_target(in_pc, in_inst) : 32'd0;
        q.push_back(e);
        if (e.taken) begin m_redir = 1'b1; m_redir_pc = e.target; end
        if (e.pre[3]) m_lock = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 7))
      0: w[6:0] = 7'h6F;
      1: w[6:0] = 7'h67;
      2, 3: w[6:0] = 7'h63;
      4: w = 32'h0000_0073;
      5: w = 32'h3020_0073;
      6: w[6:0] = 7'h73;
      default: w[6:0] = 7'h13;
    endcase
    return w;
  endfunction

  task automatic random_phase(input int n);
    logic [31:0] p;
    for (int k = 0; k < n; k++) begin
      p = $urandom; p[1:0] = 2'b00;
      set($urandom_range(0, 3) != 0, p, rand_inst(), $urandom_range(0, 9) < 6,
          $urandom_range(0, 19) == 0);
      tick();
    end
  endtask

  initial begin
    #2;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst count", count, 0);
    chk("rst redirect_valid", redirect_valid, 0);
    chk("rst redirect_pc", redirect_pc, 0);
    chk("rst out_pc", out_pc, 0);
    chk("rst out_pred_taken", out_pred_taken, 0);
    chk("model jal pre", m_pre(32'h0080_006F), 6'b000001);
    chk("model jal target", m_target(32'h8000_0000, 32'h0080_006F), 32'h8000_0008);
    chk("model beq back target", m_target(32'h100, 32'hFE00_0EE3), 32'hFC);
    chk("model ecall pre", m_pre(32'h0000_0073), 6'b011000);
    chk("model mret pre", m_pre(32'h3020_0073), 6'b101000);
    chk("model wrap target", m_target(32'hFFFF_FFFC, 32'h0080_006F), 32'h4);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with plain ALU words, then drain in order
    for (int i = 0; i < 4; i++) begin set(1, 32'(i * 4), 32'h0000_0013, 0, 0); tick(); end
    set(1, 32'h40, 32'h0000_0013, 0, 0);
    #1; chk("full count", count, 4); chk("full in_ready", in_ready, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set(0, 0, 0, 1, 0);
      #1; chk("drain pc", out_pc, 32'(i * 4));
      tick();
    end

    // JAL: redirect pulse and wrong-path word rejected
    set(1, 32'h8000_0000, 32'h0080_006F, 0, 0); tick();
    set(1, 32'h8000_0004, 32'h0000_0013, 0, 0);
    #1;
    chk("jal redirect_valid", redirect_valid, 1);
    chk("jal redirect_pc", redirect_pc, 32'h8000_0008);
    chk("jal in_ready", in_ready, 0);
    chk("jal predecode", out_predecode, 6'b000001);
    chk("jal target", out_pred_target, 32'h8000_0008);
    tick();
    set(0, 0, 0, 1, 0);
    #1; chk("jal pulse end", redirect_valid, 0);
    tick();

    // Backward branch predicted, forward branch not
    set(1, 32'h100, 32'hFE00_0EE3, 0, 0); tick();
    set(0, 0, 0, 1, 0);
    #1; chk("bwd taken", out_pred_taken, 1); chk("bwd target", out_pred_target, 32'hFC);
    chk("bwd redirect_pc", redirect_pc, 32'hFC);
    tick();
    set(1, 32'h200, 32'h0000_0463, 0, 0); tick();
    set(0, 0, 0, 1, 0);
    #1; chk("fwd taken", out_pred_taken, 0); chk("fwd target", out_pred_target, 0);
    chk("fwd redirect", redirect_valid, 0);
    tick();

    // ECALL locks fetch until dequeued; MRET pre-decode
    set(1, 32'h300, 32'h0000_0073, 0, 0); tick();
    set(1, 32'h304, 32'h0000_0013, 0, 0);
    #1; chk("ecall predecode", out_predecode, 6'b011000); chk("ecall lock", in_ready, 0);
    tick(); tick();
    set(1, 32'h304, 32'h0000_0013, 1, 0);
    #1; chk("ecall lock deq", in_ready, 0);
    tick();
    set(1, 32'h304, 32'h0000_0013, 0, 0);
    #1; chk("ecall unlock", in_ready, 1);
    tick();
    set(1, 32'h308, 32'h3020_0073, 0, 0); tick();
    set(0, 0, 0, 1, 0); tick();
    set(0, 0, 0, 1, 0);
    #1; chk("mret predecode", out_predecode, 6'b101000);
    tick();

    // Flush with three entries while a word is offered
    for (int i = 0; i < 3; i++) begin set(1, 32'h400 + 32'(i * 4), 32'h0000_0013, 0, 0); tick(); end
    set(1, 32'h500, 32'h0000_0013, 1, 1);
    #1; chk("flush in_ready", in_ready, 0);
    tick();
    #1; chk("post flush count", count, 0); chk("post flush out_valid", out_valid, 0);
    set(1, 32'hFFFF_FFFC, 32'h0080_006F, 0, 0); tick();
    set(0, 0, 0, 1, 0);
    #1; chk("wrap target", out_pred_target, 32'h4); chk("wrap redirect", redirect_pc, 32'h4);
    tick();

    random_phase(1500);

    // Asynchronous reset in the middle of traffic
    rst_n = 1'b0; set(0, 0, 0, 0, 0);
    #1;
    chk("mid rst count", count, 0);
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst redirect", redirect_valid, 0);
    chk("mid rst in_ready", in_ready, 1);
    q.delete(); m_redir = 1'b0; m_lock = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    random_phase(1500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
